keypad_4x4_scanner: RTL and testbench

//  Input-side counterpart of the 2-digit 7-seg mux: time-multiplexes a 4x4 matrix keypad
//  by driving one row low per refresh tick and sampling the columns. Debounces key

---
 rtl/keypad_4x4_scanner.sv | 194 +++++++++++++++++++
 tb/tb_keypad_4x4_scanner.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_4x4_scanner.sv
// keypad_4x4_scanner: scans a 4x4 active-low matrix keypad one row per tick,
// debounces press and release, and emits {row,col} with a one-cycle strobe.
// Optional build macro: KEYPAD_REPEAT_EN adds auto-repeat strobes while held.
module keypad_4x4_scanner #(
  parameter int CLK_FREQ_HZ    = 27_000_000,
  parameter int SCAN_HZ        = 1_000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int TICK_DIV = CLK_FREQ_HZ / SCAN_HZ;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEB_W    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_TARGET = DEB_W'(DEBOUNCE_SCANS);

  // Reject parameter sets the counters cannot represent.
  if (TICK_DIV < 2 || DEBOUNCE_SCANS < 2 || REPEAT_SCANS < 1) begin : g_bad_params
    $error("keypad_4x4_scanner: unsupported parameter values");
  end

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_PRESSED} state_e;

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [1:0]          row_idx_q, row_idx_d;
  logic [3:0]          row_n_q, row_n_d;
  logic [1:0]          col_idx_q, col_idx_d;
  logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
  logic [DEB_W-1:0]    deb_inc;
  logic [3:0]          key_code_q, key_code_d;
  logic                key_valid_q, key_valid_d;
  logic                key_held_q, key_held_d;
  logic [3:0]          col_meta_q, col_sync_q;
  logic                tick;
  logic                col_any;
  logic [1:0]          col_first;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_SCANS + 1);
  localparam logic [REP_W-1:0] REP_TARGET = REP_W'(REPEAT_SCANS);
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

  // Two-flop synchronizer for the asynchronous column inputs (idle = released).
  // NOTE: asynchronous reset on every flop here, including the synchronizer, so
  // a mid-press reset can never leave a stale "pressed" sample behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_q <= 4'hF;
      col_sync_q <= 4'hF;
    end else begin
      col_meta_q <= col_n;
      col_sync_q <= col_meta_q;
    end
  end

  assign tick    = (tick_cnt_q == TICK_LAST);
  assign deb_inc = deb_cnt_q + 1'b1;

  // Lowest-index low column wins when several are pressed on one row.
  always_comb begin
    col_any   = 1'b1;
    col_first = 2'd0;
    if      (!col_sync_q[0]) col_first = 2'd0;
    else if (!col_sync_q[1]) col_first = 2'd1;
    else if (!col_sync_q[2]) col_first = 2'd2;
    else if (!col_sync_q[3]) col_first = 2'd3;
    else                     col_any   = 1'b0;
  end

  // Next-state logic: tick divider plus the scan/debounce/pressed FSM.
  // NOTE: every variable gets its hold/default value first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
    row_idx_d   = row_idx_q;
    col_idx_d   = col_idx_q;
    deb_cnt_d   = deb_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
`endif
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (col_any) begin
            col_idx_d = col_first;
            deb_cnt_d = DEB_W'(1);
            state_d   = ST_DEBOUNCE;
          end else begin
            row_idx_d = row_idx_q + 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (col_any && (col_first == col_idx_q)) begin
            if (deb_inc == DEB_TARGET) begin
              key_valid_d = 1'b1;
              key_code_d  = {row_idx_q, col_idx_q};
              key_held_d  = 1'b1;
              deb_cnt_d   = '0;
              state_d     = ST_PRESSED;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt_d   = '0;
`endif
            end else begin
              deb_cnt_d = deb_inc;
            end
          end else begin
            // Bounce or a displacing key on the same row: restart the scan.
            deb_cnt_d = '0;
            row_idx_d = row_idx_q + 1'b1;
            state_d   = ST_SCAN;
          end
        end
        ST_PRESSED: begin
          if (col_sync_q[col_idx_q] && (deb_inc == DEB_TARGET)) begin
            deb_cnt_d  = '0;
            key_held_d = 1'b0;
            row_idx_d  = row_idx_q + 1'b1;
            state_d    = ST_SCAN;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_d  = '0;
`endif
          end else begin
            deb_cnt_d = col_sync_q[col_idx_q] ? deb_inc : '0;
`ifdef KEYPAD_REPEAT_EN
            if (rep_cnt_q + 1'b1 == REP_TARGET) begin
              key_valid_d = 1'b1;
              rep_cnt_d   = '0;
            end else begin
              rep_cnt_d = rep_cnt_q + 1'b1;
            end
`endif
          end
        end
        default: begin
          state_d   = ST_SCAN;
          deb_cnt_d = '0;
        end
      endcase
    end
    row_n_d = ~(4'b0001 << row_idx_d);
  end

  // State registers; row drive is registered so the keypad sees no decode glitches.
  // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SCAN;
      tick_cnt_q  <= '0;
      row_idx_q   <= 2'd0;
      row_n_q     <= 4'b1110;
      col_idx_q   <= 2'd0;
      deb_cnt_q   <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      row_idx_q   <= row_idx_d;
      row_n_q     <= row_n_d;
      col_idx_q   <= col_idx_d;
      deb_cnt_q   <= deb_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
`endif
    end
  end

  assign row_n     = row_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_4x4_scanner.sv
// tb_keypad_4x4_scanner: directed tests with a behavioural 4x4 key matrix.
// Tick every 10 clocks, 3-tick debounce, 5-tick repeat (when KEYPAD_REPEAT_EN).
module tb_keypad_4x4_scanner;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_ON = 1;
`else
  localparam int REP_ON = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys;       // keys[r*4+c] = 1 means key (row r, col c) is pressed

  int checks;
  int failures;
  int tk;                  // ticks since last reset release
  int cyc;                 // rising edges since last reset release
  int vcount;              // key_valid strobes seen
  int vcyc;                // edge number of the latest strobe
  int base;
  logic [3:0] rot [4];

  keypad_4x4_scanner #(
    .CLK_FREQ_HZ   (100),
    .SCAN_HZ       (10),
    .DEBOUNCE_SCANS(3),
    .REPEAT_SCANS  (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .col_n    (col_n),
    .row_n    (row_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (key_valid) begin
      vcount <= vcount + 1;
      vcyc   <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n ticks; lands just after the negedge following the tick edge.
  task automatic run_ticks(input int n);
    repeat (n * 10) @(posedge clk);
    #6;
    tk += n;
  endtask

  initial begin
    checks = 0; failures = 0; tk = 0; vcount = 0; vcyc = 0;
    rot[0] = 4'b1110; rot[1] = 4'b1101; rot[2] = 4'b1011; rot[3] = 4'b0111;
    keys  = '0;
    rst_n = 1'b0;

    // 1: reset values, then free-running row rotation
    repeat (3) @(posedge clk);
    #1;
    check("rst_row_n", 32'(row_n), 32'(4'b1110));
    check("rst_key_code", 32'(key_code), 32'd0);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_held", 32'(key_held), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tk = 0;
    for (int i = 1; i <= 3; i++) begin
      run_ticks(1);
      check($sformatf("rotate_t%0d", tk), 32'(row_n), 32'(rot[tk % 4]));
    end

    // 2: clean press of row2/col1 while row3 is active
    base = vcount;
    keys[9] = 1'b1;
    run_ticks(3);                                   // tk6: row2 now driven
    check("press_row2_active", 32'(row_n), 32'(4'b1011));
    run_ticks(1);                                   // tk7: captured, row frozen
    check("press_row_frozen", 32'(row_n), 32'(4'b1011));
    run_ticks(1);                                   // tk8: second agreeing tick
    check("press_no_early_strobe", 32'(vcount), 32'(base));
    run_ticks(1);                                   // tk9: accepted
    check("press_key_valid", 32'(key_valid), 32'd1);
    check("press_key_code", 32'(key_code), 32'(4'b1001));
    check("press_key_held", 32'(key_held), 32'd1);
    check("press_strobe_count", 32'(vcount), 32'(base + 1));
    check("press_strobe_edge", 32'(vcyc), 32'(tk * 10));
    run_ticks(7);                                   // tk16: still held
    check("hold_single_strobe", 32'(vcount), 32'(base + 1));
    check("hold_key_held", 32'(key_held), 32'd1);
    keys = '0;
    run_ticks(2);                                   // tk18: release 2/3
    check("release_held_2", 32'(key_held), 32'd1);
    run_ticks(1);                                   // tk19: release accepted
    check("release_held_0", 32'(key_held), 32'd0);
    check("release_row3", 32'(row_n), 32'(4'b0111));
    run_ticks(1);                                   // tk20
    check("resume_row0", 32'(row_n), 32'(4'b1110));

    // 3: one-tick bounce on row1/col1
    run_ticks(1);                                   // tk21: row1 driven
    check("bounce_row1", 32'(row_n), 32'(4'b1101));
    keys[5] = 1'b1;
    run_ticks(1);                                   // tk22: captured
    check("bounce_row_frozen", 32'(row_n), 32'(4'b1101));
    keys = '0;
    run_ticks(1);                                   // tk23: abandoned
    check("bounce_row_advance", 32'(row_n), 32'(4'b1011));
    check("bounce_code_kept", 32'(key_code), 32'(4'b1001));
    check("bounce_no_strobe", 32'(vcount), 32'(base + 1));
    check("bounce_not_held", 32'(key_held), 32'd0);

    // 4: row0 cols 1 and 3 together -> col 1 wins
    run_ticks(2);                                   // tk25: row0 driven
    check("simul_row0", 32'(row_n), 32'(4'b1110));
    keys[1] = 1'b1;
    keys[3] = 1'b1;
    base = vcount;
    run_ticks(3);                                   // tk28: accepted
    check("simul_key_code", 32'(key_code), 32'(4'b0001));
    check("simul_strobe_edge", 32'(vcyc), 32'(tk * 10));
    run_ticks(2);
    keys = '0;
    run_ticks(3);                                   // tk33: released
    check("simul_one_strobe", 32'(vcount), 32'(base + 1));
    check("simul_released", 32'(key_held), 32'd0);
    check("simul_row1", 32'(row_n), 32'(4'b1101));

    // 5: reset while pressed, key kept down across reset
    keys[2] = 1'b1;
    base = vcount;
    run_ticks(6);                                   // tk39: accepted
    check("rstmid_key_code", 32'(key_code), 32'(4'b0010));
    check("rstmid_strobe", 32'(vcount), 32'(base + 1));
    run_ticks(1);
    check("rstmid_held", 32'(key_held), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_row_n", 32'(row_n), 32'(4'b1110));
    check("rstmid_code_cleared", 32'(key_code), 32'd0);
    check("rstmid_valid_cleared", 32'(key_valid), 32'd0);
    check("rstmid_held_cleared", 32'(key_held), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tk = 0;
    base = vcount;
    run_ticks(2);
    check("redetect_not_yet", 32'(vcount), 32'(base));
    run_ticks(1);                                   // tk3: re-accepted
    check("redetect_strobe", 32'(vcount), 32'(base + 1));
    check("redetect_edge", 32'(vcyc), 32'(tk * 10));
    check("redetect_code", 32'(key_code), 32'(4'b0010));
    keys = '0;
    run_ticks(3);                                   // tk6: released, row1
    check("redetect_release", 32'(key_held), 32'd0);
    check("redetect_row1", 32'(row_n), 32'(4'b1101));

    // 6: long hold of row3/col3 (repeat strobes only with KEYPAD_REPEAT_EN)
    keys[15] = 1'b1;
    base = vcount;
    run_ticks(5);                                   // tk11: accepted
    check("long_accept", 32'(vcount), 32'(base + 1));
    check("long_accept_edge", 32'(vcyc), 32'(tk * 10));
    check("long_code", 32'(key_code), 32'(4'b1111));
    base = vcount;
    for (int t = 1; t <= 16; t++) begin
      run_ticks(1);
      if ((t % 5) == 0 || t == 16) begin
        check($sformatf("long_strobes_t%0d", t), 32'(vcount), 32'(base + REP_ON * (t / 5)));
        check($sformatf("long_code_t%0d", t), 32'(key_code), 32'(4'b1111));
      end
    end
    keys = '0;
    run_ticks(3);
    check("long_released", 32'(key_held), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
